// File: rtl/i_cache_line.sv
// i_cache_line: set-associative instruction cache sitting between the MIPS
// fetch port and the SRAM-like bus bridge. Hits return in the request cycle.
// Misses refill the whole line critical-word-first, issuing one single-word
// read at a time. The victim way comes from a tree pseudo-LRU per set.
module i_cache_line #(
  parameter int INDEX_WIDTH       = 6,
  parameter int WORD_OFFSET_WIDTH = 2,
  parameter int WAY_WIDTH         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  input  logic        inv_all,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok
);

  localparam int TAG_WIDTH = 30 - INDEX_WIDTH - WORD_OFFSET_WIDTH;
  localparam int WAYS      = 1 << WAY_WIDTH;
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << WORD_OFFSET_WIDTH;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, state_next;

  // Fetch address split into word offset, set index and tag.
  logic [WORD_OFFSET_WIDTH-1:0] req_word;
  logic [INDEX_WIDTH-1:0]       req_index;
  logic [TAG_WIDTH-1:0]         req_tag;

  assign req_word  = cpu_inst_addr[WORD_OFFSET_WIDTH+1:2];
  assign req_index = cpu_inst_addr[WORD_OFFSET_WIDTH+INDEX_WIDTH+1:WORD_OFFSET_WIDTH+2];
  assign req_tag   = cpu_inst_addr[31:32-TAG_WIDTH];

  // The fetch port is read-only; the write-side inputs are sunk here.
  logic unused_inputs;
  assign unused_inputs = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata, cpu_inst_addr[1:0]};

  // Storage: valid bits and PLRU trees are reset, tags and data are not.
  logic [SETS-1:0]      valid_q [WAYS];
  logic [WAYS-2:0]      plru_q  [SETS];
  logic [TAG_WIDTH-1:0] tag_mem [WAYS][SETS];
  logic [31:0]          data_mem[WAYS][SETS][WORDS];

  // Refill context latched on a miss.
  logic [TAG_WIDTH-1:0]         r_tag;
  logic [INDEX_WIDTH-1:0]       r_index;
  logic [WORD_OFFSET_WIDTH-1:0] r_word;
  logic [WAY_WIDTH-1:0]         r_way;
  logic [WORD_OFFSET_WIDTH-1:0] cnt_q;
  logic                         outstanding_q;
  logic                         inv_pending_q;
  logic [31:0]                  crit_q;

  logic [WORD_OFFSET_WIDTH-1:0] bus_offset;
  logic                         fill_beat;
  logic                         fill_last;
  logic                         miss_start;

  logic                 hit;
  logic [WAY_WIDTH-1:0] hit_way;
  logic [31:0]          hit_word;
  logic                 found_invalid;
  logic [WAY_WIDTH-1:0] victim;

  // Tree PLRU, nodes stored heap-style (children of n are 2n+1 and 2n+2).
  // A node bit of 0 points the victim into the lower half.
  function automatic logic [WAY_WIDTH-1:0] plru_victim(input logic [WAYS-2:0] tree);
    logic [WAY_WIDTH-1:0] n;
    logic [WAY_WIDTH-1:0] v;
    logic                 b;
    n = '0;
    v = '0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      b = tree[n];
      v[WAY_WIDTH-1-l] = b;
      n = WAY_WIDTH'(2 * int'(n) + 1 + int'(b));
    end
    return v;
  endfunction

  // Every node on the accessed way's path is flipped to point away from it.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree,
                                                 input logic [WAY_WIDTH-1:0] way);
    logic [WAYS-2:0]      r;
    logic [WAY_WIDTH-1:0] n;
    logic                 b;
    r = tree;
    n = '0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      b = way[WAY_WIDTH-1-l];
      r[n] = ~b;
      n = WAY_WIDTH'(2 * int'(n) + 1 + int'(b));
    end
    return r;
  endfunction

  // Tag compare across all ways of the addressed set.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hit      = 1'b0;
    hit_way  = '0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][req_index] && tag_mem[w][req_index] == req_tag) begin
        hit      = 1'b1;
        hit_way  = WAY_WIDTH'(w);
        hit_word = data_mem[w][req_index][req_word];
      end
    end
  end

  // Victim selection: lowest invalid way first, otherwise the PLRU choice.
  always_comb begin
    found_invalid = 1'b0;
    victim        = plru_victim(plru_q[req_index]);
    for (int w = 0; w < WAYS; w++) begin
      if (!found_invalid && !valid_q[w][req_index]) begin
        found_invalid = 1'b1;
        victim        = WAY_WIDTH'(w);
      end
    end
  end

  assign miss_start = (state == IDLE) && cpu_inst_req && !hit;
  assign fill_beat  = (state == REFILL) && outstanding_q && cache_inst_data_ok;
  assign fill_last  = fill_beat && (cnt_q == '1);
  assign bus_offset = r_word + cnt_q;

  assign cache_inst_req   = (state == REFILL) && !outstanding_q;
  assign cache_inst_addr  = {r_tag, r_index, bus_offset, 2'b00};
  assign cache_inst_wr    = 1'b0;
  assign cache_inst_size  = 2'b10;
  assign cache_inst_wdata = '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and core-side handshake.
  always_comb begin
    state_next       = state;
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    cpu_inst_rdata   = '0;
    case (state)
      IDLE: begin
        if (cpu_inst_req) begin
          if (hit) begin
            cpu_inst_addr_ok = 1'b1;
            cpu_inst_data_ok = 1'b1;
            cpu_inst_rdata   = hit_word;
          end else begin
            state_next = REFILL;
          end
        end
      end
      REFILL: begin
        if (fill_last) begin
          state_next       = IDLE;
          cpu_inst_addr_ok = 1'b1;
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = (cnt_q == '0) ? cache_inst_rdata : crit_q;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Refill bookkeeping: miss context, beat counter, bus handshake, pending invalidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag         <= '0;
      r_index       <= '0;
      r_word        <= '0;
      r_way         <= '0;
      cnt_q         <= '0;
      outstanding_q <= 1'b0;
      inv_pending_q <= 1'b0;
      crit_q        <= '0;
    end else begin
      if (miss_start) begin
        r_tag         <= req_tag;
        r_index       <= req_index;
        r_word        <= req_word;
        r_way         <= victim;
        cnt_q         <= '0;
        outstanding_q <= 1'b0;
      end
      if (cache_inst_req && cache_inst_addr_ok) begin
        outstanding_q <= 1'b1;
      end
      if (fill_beat) begin
        outstanding_q <= 1'b0;
        cnt_q         <= cnt_q + 1'b1;
        if (cnt_q == '0) begin
          crit_q <= cache_inst_rdata;
        end
      end
      if (state == REFILL) begin
        if (fill_last) begin
          inv_pending_q <= 1'b0;
        end else if (inv_all) begin
          inv_pending_q <= 1'b1;
        end
      end
    end
  end

  // Valid bits and PLRU trees: hit/fill updates and global invalidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
      end
    end else begin
      if (state == IDLE) begin
        if (cpu_inst_req && hit) begin
          plru_q[req_index] <= plru_touch(plru_q[req_index], hit_way);
        end
        if (inv_all) begin
          for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
          end
        end
      end else if (fill_last) begin
        plru_q[r_index] <= plru_touch(plru_q[r_index], r_way);
        if (inv_all || inv_pending_q) begin
          for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
          end
        end else begin
          valid_q[r_way][r_index] <= 1'b1;
        end
      end
    end
  end

  // Tag and data arrays: written only by refills.
  // NOTE: the arrays are not reset; the valid bits alone decide whether their contents are used.
  always_ff @(posedge clk) begin
    if (fill_beat) begin
      data_mem[r_way][r_index][bus_offset] <= cache_inst_rdata;
    end
    if (fill_last) begin
      tag_mem[r_way][r_index] <= r_tag;
    end
  end

endmodule

// File: tb/tb_i_cache_line.sv
// Self-checking bench for i_cache_line: a bus model returning data equal to
// the word address, with expected bus addresses and core results queued as
// scoreboards when each fetch is driven.
module tb_i_cache_line;

  logic        clk;
  logic        rst;
  logic        cpu_inst_req;
  logic        cpu_inst_wr;
  logic [1:0]  cpu_inst_size;
  logic [31:0] cpu_inst_addr;
  logic [31:0] cpu_inst_wdata;
  logic [31:0] cpu_inst_rdata;
  logic        cpu_inst_addr_ok;
  logic        cpu_inst_data_ok;
  logic        inv_all;
  logic        cache_inst_req;
  logic        cache_inst_wr;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr;
  logic [31:0] cache_inst_wdata;
  logic [31:0] cache_inst_rdata;
  logic        cache_inst_addr_ok;
  logic        cache_inst_data_ok;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_bus_q[$];
  logic [31:0] core_exp_q[$];
  bit          inject_stray = 1'b0;

  typedef struct {
    logic [31:0] addr;
    bit          exp_hit;
    logic [31:0] exp_rdata;
  } vec_t;

  i_cache_line dut (
    .clk                (clk),
    .rst                (rst),
    .cpu_inst_req       (cpu_inst_req),
    .cpu_inst_wr        (cpu_inst_wr),
    .cpu_inst_size      (cpu_inst_size),
    .cpu_inst_addr      (cpu_inst_addr),
    .cpu_inst_wdata     (cpu_inst_wdata),
    .cpu_inst_rdata     (cpu_inst_rdata),
    .cpu_inst_addr_ok   (cpu_inst_addr_ok),
    .cpu_inst_data_ok   (cpu_inst_data_ok),
    .inv_all            (inv_all),
    .cache_inst_req     (cache_inst_req),
    .cache_inst_wr      (cache_inst_wr),
    .cache_inst_size    (cache_inst_size),
    .cache_inst_addr    (cache_inst_addr),
    .cache_inst_wdata   (cache_inst_wdata),
    .cache_inst_rdata   (cache_inst_rdata),
    .cache_inst_addr_ok (cache_inst_addr_ok),
    .cache_inst_data_ok (cache_inst_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave: accepts a request, answers 1..3 cycles later with data = address.
  initial begin
    int          lat;
    bit          busy;
    logic [31:0] pend_addr;
    logic [31:0] exp_addr;
    busy               = 1'b0;
    lat                = 0;
    pend_addr          = '0;
    cache_inst_addr_ok = 1'b0;
    cache_inst_data_ok = 1'b0;
    cache_inst_rdata   = '0;
    forever begin
      @(posedge clk);
      #2;
      cache_inst_addr_ok = 1'b0;
      cache_inst_data_ok = 1'b0;
      cache_inst_rdata   = '0;
      if (inject_stray) begin
        cache_inst_data_ok = 1'b1;
        cache_inst_rdata   = 32'hDEAD_BEEF;
      end else if (busy) begin
        if (lat == 0) begin
          cache_inst_data_ok = 1'b1;
          cache_inst_rdata   = pend_addr;
          busy               = 1'b0;
        end else begin
          lat--;
        end
      end else if (cache_inst_req) begin
        cache_inst_addr_ok = 1'b1;
        pend_addr          = cache_inst_addr;
        busy               = 1'b1;
        lat                = $urandom_range(0, 2);
        if (exp_bus_q.size() == 0) begin
          check("unexpected_bus_read", cache_inst_addr, 32'hFFFF_FFFF);
        end else begin
          exp_addr = exp_bus_q.pop_front();
          check("bus_addr_order", cache_inst_addr, exp_addr);
        end
      end
    end
  end

  // Drive one fetch from the next cycle on and wait for its data. On a miss the
  // four expected bus addresses (critical word first, wrapping) are queued.
  // inv_after >= 0 pulses inv_all for one cycle after that many bus beats.
  task automatic fetch(input logic [31:0] addr, input bit exp_hit, input logic [31:0] exp_rdata,
                       input bit inv_with_req, input int inv_after);
    logic [31:0] base;
    logic [31:0] got_exp;
    int          n;
    int          beats;
    bit          pulsed;
    base   = {addr[31:4], 4'h0};
    n      = 0;
    beats  = 0;
    pulsed = 1'b0;
    if (!exp_hit) begin
      for (int k = 0; k < 4; k++) begin
        exp_bus_q.push_back(base + 32'(((int'(addr[3:2]) + k) % 4) * 4));
      end
    end
    core_exp_q.push_back(exp_rdata);
    @(posedge clk);
    #1;
    cpu_inst_req  = 1'b1;
    cpu_inst_addr = addr;
    inv_all       = inv_with_req;
    #2;
    while (!cpu_inst_data_ok) begin
      if (n == 0) check("rdata_zero_without_data_ok", cpu_inst_rdata, 32'h0);
      if (cache_inst_data_ok) beats++;
      if (n >= 100) begin
        checks++;
        failures++;
        $display("FAIL fetch_timeout addr=%h: no data_ok after %0d cycles, required within 100", addr, n);
        core_exp_q.delete();
        exp_bus_q.delete();
        cpu_inst_req = 1'b0;
        inv_all      = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      inv_all = (inv_after >= 0) && !pulsed && (beats == inv_after);
      if (inv_all) pulsed = 1'b1;
      #2;
      n++;
    end
    got_exp = core_exp_q.pop_front();
    check($sformatf("rdata_%h", addr), cpu_inst_rdata, got_exp);
    check($sformatf("addr_ok_%h", addr), 32'(cpu_inst_addr_ok), 32'h1);
    check($sformatf("hit_%h", addr), 32'(n == 0), 32'(exp_hit));
    if (exp_hit) check($sformatf("no_bus_req_on_hit_%h", addr), 32'(cache_inst_req), 32'h0);
    check($sformatf("bus_reads_done_%h", addr), 32'(exp_bus_q.size()), 32'h0);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    cpu_inst_req = 1'b0;
    inv_all      = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst          = 1'b1;
    cpu_inst_req = 1'b0;
    inv_all      = 1'b0;
    #1;
    check("reset_bus_req", 32'(cache_inst_req), 32'h0);
    check("reset_addr_ok", 32'(cpu_inst_addr_ok), 32'h0);
    check("reset_data_ok", 32'(cpu_inst_data_ok), 32'h0);
    check("reset_rdata", cpu_inst_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl_a[5];
    vec_t tbl_b[10];
    int   beats;
    int   n;

    tbl_a[0] = '{addr: 32'h1008, exp_hit: 1'b0, exp_rdata: 32'h1008};
    tbl_a[1] = '{addr: 32'h1000, exp_hit: 1'b1, exp_rdata: 32'h1000};
    tbl_a[2] = '{addr: 32'h1004, exp_hit: 1'b1, exp_rdata: 32'h1004};
    tbl_a[3] = '{addr: 32'h1008, exp_hit: 1'b1, exp_rdata: 32'h1008};
    tbl_a[4] = '{addr: 32'h100C, exp_hit: 1'b1, exp_rdata: 32'h100C};

    // Index 0 fills ways 0..3, a hit on way 0 makes way 2 the PLRU victim
    // for 0x1000; 0x0/0x400/0xC00 survive and 0x800 is gone.
    tbl_b[0] = '{addr: 32'h0000, exp_hit: 1'b0, exp_rdata: 32'h0000};
    tbl_b[1] = '{addr: 32'h0400, exp_hit: 1'b0, exp_rdata: 32'h0400};
    tbl_b[2] = '{addr: 32'h0800, exp_hit: 1'b0, exp_rdata: 32'h0800};
    tbl_b[3] = '{addr: 32'h0C00, exp_hit: 1'b0, exp_rdata: 32'h0C00};
    tbl_b[4] = '{addr: 32'h0000, exp_hit: 1'b1, exp_rdata: 32'h0000};
    tbl_b[5] = '{addr: 32'h1000, exp_hit: 1'b0, exp_rdata: 32'h1000};
    tbl_b[6] = '{addr: 32'h0004, exp_hit: 1'b1, exp_rdata: 32'h0004};
    tbl_b[7] = '{addr: 32'h0408, exp_hit: 1'b1, exp_rdata: 32'h0408};
    tbl_b[8] = '{addr: 32'h0C0C, exp_hit: 1'b1, exp_rdata: 32'h0C0C};
    tbl_b[9] = '{addr: 32'h0800, exp_hit: 1'b0, exp_rdata: 32'h0800};

    rst            = 1'b0;
    cpu_inst_req   = 1'b0;
    cpu_inst_wr    = 1'b0;
    cpu_inst_size  = 2'b10;
    cpu_inst_addr  = '0;
    cpu_inst_wdata = '0;
    inv_all        = 1'b0;

    do_reset();
    check("tied_bus_wr", 32'(cache_inst_wr), 32'h0);
    check("tied_bus_size", 32'(cache_inst_size), 32'h2);

    // Critical-word-first miss followed by a back-to-back hit stream.
    for (int i = 0; i < 5; i++) begin
      fetch(tbl_a[i].addr, tbl_a[i].exp_hit, tbl_a[i].exp_rdata, 1'b0, -1);
    end
    idle();

    // PLRU replacement in a full set.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      fetch(tbl_b[i].addr, tbl_b[i].exp_hit, tbl_b[i].exp_rdata, 1'b0, -1);
    end
    idle();

    // inv_all during the second refill word: data still delivered, line not kept.
    fetch(32'h3010, 1'b0, 32'h3010, 1'b0, 1);
    idle();
    fetch(32'h3010, 1'b0, 32'h3010, 1'b0, -1);
    fetch(32'h0C00, 1'b0, 32'h0C00, 1'b0, -1);
    idle();

    // Reset after two refill words.
    exp_bus_q.push_back(32'h5020);
    exp_bus_q.push_back(32'h5024);
    @(posedge clk);
    #1;
    cpu_inst_req  = 1'b1;
    cpu_inst_addr = 32'h5020;
    #2;
    beats = 0;
    n     = 0;
    while (beats < 2 && n < 100) begin
      if (cache_inst_data_ok) beats++;
      if (beats < 2) begin
        @(posedge clk);
        #3;
        n++;
      end
    end
    check("refill_two_beats_seen", 32'(beats), 32'h2);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    cpu_inst_req = 1'b0;
    #1;
    check("bus_req_drops_on_reset", 32'(cache_inst_req), 32'h0);
    check("data_ok_low_on_reset", 32'(cpu_inst_data_ok), 32'h0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    inject_stray = 1'b1;
    #2;
    check("stray_beat_present", 32'(cache_inst_data_ok), 32'h1);
    @(posedge clk);
    #1;
    inject_stray = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      check("no_bus_req_after_stray", 32'(cache_inst_req), 32'h0);
      check("no_data_ok_after_stray", 32'(cpu_inst_data_ok), 32'h0);
      @(posedge clk);
      #1;
    end
    check("partial_refill_reads", 32'(exp_bus_q.size()), 32'h0);
    fetch(32'h5020, 1'b0, 32'h5020, 1'b0, -1);
    idle();

    // inv_all coincident with a hit: served now, gone next cycle.
    fetch(32'h1000, 1'b0, 32'h1000, 1'b0, -1);
    fetch(32'h1004, 1'b1, 32'h1004, 1'b1, -1);
    fetch(32'h1000, 1'b0, 32'h1000, 1'b0, -1);
    idle();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i_cache_line.md
# i_cache_line

Parametrised set-associative instruction cache between the MIPS core fetch port and the SRAM-like AXI bridge.
- Line size, set count and associativity are configurable.
- Misses refill the whole line critical-word-first, as a series of single-word bus reads; victims are chosen by tree pseudo-LRU.
- A global invalidate input supports cache maintenance.

## Interface
- INDEX_WIDTH, 6, log2 of sets per way
- WORD_OFFSET_WIDTH, 2, log2 of 32-bit words per line
- WAY_WIDTH, 2, log2 of ways (≥1); PLRU uses 2^WAY_WIDTH−1 bits per set
- Derived: TAG_WIDTH = 30 − INDEX_WIDTH − WORD_OFFSET_WIDTH

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_inst_req  in  1  fetch request, held by core until addr_ok
- cpu_inst_wr  in  1  ignored
- cpu_inst_size  in  2  ignored
- cpu_inst_addr  in  32  fetch address; bits [1:0] ignored
- cpu_inst_wdata  in  32  ignored
- cpu_inst_rdata  out  32  fetched word
- cpu_inst_addr_ok  out  1  request accepted
- cpu_inst_data_ok  out  1  rdata valid
- inv_all  in  1  one-cycle pulse: invalidate every line
- cache_inst_req  out  1  bus read request
- cache_inst_wr  out  1  tied 0
- cache_inst_size  out  2  tied 2'b10
- cache_inst_addr  out  32  word-aligned bus address
- cache_inst_wdata  out  32  tied 0
- cache_inst_rdata  in  32  bus read data
- cache_inst_addr_ok  in  1  bus accepted request
- cache_inst_data_ok  in  1  bus data valid

## Operation
- Address split: word = addr[WORD_OFFSET_WIDTH+1:2]; index = next INDEX_WIDTH bits; tag = remaining upper bits.
- Storage per way/set: valid bit, tag, line of 2^WORD_OFFSET_WIDTH words. PLRU tree per set.
- Hit: any valid way in the set has a matching tag.
- FSM states: IDLE, REFILL.
- IDLE, req & hit:
  - addr_ok and data_ok both assert combinationally; rdata = hit word.
  - PLRU updated at the clock edge.
- IDLE, req & miss:
  - Latch tag, index, word and victim way; go to REFILL.
  - Victim = lowest-numbered invalid way; if none, the PLRU victim.
- REFILL:
  - Issue 2^WORD_OFFSET_WIDTH reads, one outstanding at a time. The first is for the requested word; the offset then increments modulo line size (wrap-around).
  - cache_inst_addr = {tag, index, offset, 2'b00}.
  - cache_inst_req is high from REFILL entry, or from the cycle after the previous data_ok, until addr_ok is sampled high.
  - Each data_ok writes the word into the victim line. The first returned word is also captured in a critical-word register.
  - On the last data_ok: write the victim's tag and set its valid bit, update PLRU toward the victim, and return to IDLE.
  - In that same cycle: cpu_inst_addr_ok = cpu_inst_data_ok = 1 and rdata = critical-word register.
- PLRU encoding:
  - Node bit 0 means the victim lies in the lower half, 1 the upper half.
  - An access sets every node on the accessed way's path to point away from that way.
- cache_inst_data_ok is ignored in IDLE.
- inv_all:
  - In IDLE, clears all valid bits at the edge. A same-cycle hit is still served from the pre-invalidate contents.
  - In REFILL, the invalidate is recorded as pending. It is applied at the completion edge and also wins over the valid-set of the just-filled line. The core still receives the fill data.
- No write path: cpu_inst_wr and the write-related bus signals are never used.

## Timing
- Hit latency: 0 cycles (data_ok in the request cycle). Back-to-back hits sustain 1 per cycle.
- Miss latency: sum of the line's bus round-trips plus 1 cycle (IDLE→REFILL). Core data_ok coincides with the last bus data_ok.
- Reset (asynchronous, immediate):
  - state = IDLE; all valid bits, PLRU bits, refill counter and pending-invalidate cleared.
  - cache_inst_req = 0, cpu_inst_addr_ok = 0, cpu_inst_data_ok = 0, cpu_inst_rdata = 0.
- Reset mid-refill: the partial line stays invalid. A stray bus data_ok after reset is ignored.
- cpu_inst_rdata = 0 whenever data_ok is low.

## Test plan
Defaults throughout; memory model returns data = word address.
- Reset, then fetch 0x0000_1008 → miss. Bus addresses in order: 0x1008, 0x100C, 0x1000, 0x1004. Core data_ok on the 4th bus data_ok with rdata = 0x1008. Then fetch 0x1000 → same-cycle hit, rdata = 0x1000, no bus request.
- Fill index 0 with 0x0, 0x400, 0x800, 0xC00 (ways 0–3), hit 0x0, then fetch 0x1000 → way 2 evicted. Afterwards 0x800 misses; 0x0, 0x400 and 0xC00 hit.
- Pulse inv_all during the 2nd word of a refill → core still gets data at refill end. The same address then misses and issues 4 bus reads.
- Assert rst after 2 refill words → cache_inst_req drops immediately. A following bus data_ok causes no change. A refetch issues 4 reads.
- Hit stream 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles → 4 data_ok in 4 cycles, cache_inst_req stays 0.
- inv_all coincident with a hit on 0x1000 in IDLE → hit returned that cycle; next-cycle fetch of 0x1000 misses.
